// File: rtl/crypto_itf_pkg.sv
// crypto_itf_pkg: shared state encoding, control/status bit positions and index helpers
package crypto_itf_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CTL_RST = 0;
  localparam int CTL_LOAD = 1;
  localparam int CTL_READ = 2;
  localparam int CTL_START = 3;
  localparam int ST_BUSY = 0;
  localparam int ST_END = 1;
  localparam int ST_ERR = 2;
  localparam int ST_CNT = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // status word sits directly after the last output word
  function automatic int status_addr(input int out_words);
    return out_words;
  endfunction
endpackage

// File: rtl/itf_reg_bank.sv
// itf_reg_bank: word-addressed register array with clear, parallel capture and single-word write
module itf_reg_bank #(
  parameter int WORDS = 8,
  parameter int W = 64,
  parameter int AW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [W-1:0]            wdata,
  input  logic                    cap,
  input  logic [WORDS-1:0][W-1:0] cap_data,
  output logic [WORDS-1:0][W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (cap) q <= cap_data;
    else if (we) q[addr] <= wdata;
endmodule

// File: rtl/crypto_core_itf.sv
// crypto_core_itf: host register interface sequencing a crypto core through IDLE/RUN/DONE.
// Define CRYPTO_ITF_TIMEOUT_EN to add the RUN cycle limit (TIMEOUT) with error reporting.
module crypto_core_itf
  import crypto_itf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IN_WORDS = 8,
  parameter int OUT_WORDS = 4,
  parameter int ADDR_W = 64,
  parameter int CNT_W = 32
`ifdef CRYPTO_ITF_TIMEOUT_EN
  , parameter int TIMEOUT = 2**20
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    control,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          end_op,
  output logic                          busy,
  output logic                          core_start,
  output logic [IN_WORDS*DATA_W-1:0]    core_din,
  input  logic [OUT_WORDS*DATA_W-1:0]   core_dout,
  input  logic                          core_valid
);
  localparam int IA = idx_w(IN_WORDS);
  localparam int OA = idx_w(OUT_WORDS);
  state_t state, state_d;
  logic start, read, load, rst_itf;
  logic go, cap, to_hit, in_we, err;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CNT_W+7:0] st;
  logic [DATA_W-1:0] rdata;
  logic [IN_WORDS-1:0][DATA_W-1:0] in_q;
  logic [OUT_WORDS-1:0][DATA_W-1:0] out_q;
  assign rst_itf = control[CTL_RST];
  assign load = control[CTL_LOAD];
  assign read = control[CTL_READ];
  assign start = control[CTL_START];
  assign busy = state == RUN;
  assign end_op = state == DONE;
  // counter is zero only in the first RUN cycle since it saturates instead of wrapping
  assign core_start = busy && cnt == '0;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign in_we = load && !busy && address < ADDR_W'(IN_WORDS);
  assign core_din = in_q;
  always_comb begin
    go = !rst_itf && start && !busy;
    cap = !rst_itf && busy && core_valid;
`ifdef CRYPTO_ITF_TIMEOUT_EN
    to_hit = !rst_itf && busy && !core_valid && cnt_inc == CNT_W'(TIMEOUT);
`else
    to_hit = 1'b0;
`endif
    state_d = rst_itf ? IDLE : go ? RUN : (cap || to_hit) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= (rst_itf || go) ? '0 : busy ? cnt_inc : cnt;
    end
`ifdef CRYPTO_ITF_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else err <= (rst_itf || go) ? 1'b0 : to_hit ? 1'b1 : err;
`else
  assign err = 1'b0;
`endif
  assign st = {cnt, 5'd0, err, end_op, busy};
  assign rdata = address == ADDR_W'(status_addr(OUT_WORDS)) ? DATA_W'(st) :
                 address < ADDR_W'(OUT_WORDS) ? out_q[address[OA-1:0]] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_out <= '0;
    else if (read) data_out <= rdata;
  itf_reg_bank #(.WORDS(IN_WORDS), .W(DATA_W), .AW(IA)) u_in (
    .clk(clk), .rst(rst), .clr(rst_itf), .we(in_we), .addr(address[IA-1:0]),
    .wdata(data_in), .cap(1'b0), .cap_data('0), .q(in_q)
  );
  // a timeout wipes the result bank so software never reads a stale result
  itf_reg_bank #(.WORDS(OUT_WORDS), .W(DATA_W), .AW(OA)) u_out (
    .clk(clk), .rst(rst), .clr(rst_itf || to_hit), .we(1'b0), .addr('0),
    .wdata('0), .cap(cap), .cap_data(core_dout), .q(out_q)
  );
endmodule

// File: tb/tb_crypto_core_itf.sv
// tb_crypto_core_itf: directed table-driven bench for crypto_core_itf (timeout section under CRYPTO_ITF_TIMEOUT_EN)
module tb_crypto_core_itf;
  localparam logic [3:0] C_RST = 4'd1, C_LOAD = 4'd2, C_READ = 4'd4, C_START = 4'd8;
  localparam logic [63:0] K = 64'h1111111111111111;
  localparam logic [63:0] A5 = 64'hA5A5A5A5A5A5A5A5;
  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] addr;
    logic [63:0] din;
    logic [63:0] dout;
    logic        bsy;
    logic        eop;
  } vec_t;
  logic clk = 0, rst = 0, core_valid = 0;
  logic [3:0] control = 0;
  logic [63:0] address = 0, data_in = 0, data_out;
  logic end_op, busy, core_start;
  logic [511:0] core_din;
  logic [255:0] core_dout = 0;
  logic [7:0][63:0] din_m = '0;
  vec_t t1[12], t2[9];
  int n_vec = 0, n_bad = 0;
  crypto_core_itf #(
`ifdef CRYPTO_ITF_TIMEOUT_EN
    .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .control(control), .address(address), .data_in(data_in),
    .data_out(data_out), .end_op(end_op), .busy(busy), .core_start(core_start),
    .core_din(core_din), .core_dout(core_dout), .core_valid(core_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_din(input string n);
    n_vec++;
    if (core_din !== din_m) begin
      n_bad++;
      $display("FAIL %s: core_din got %0h expected %0h", n, core_din, din_m);
    end
  endtask
  task automatic step(input logic [3:0] c, input logic [63:0] a, input logic [63:0] d);
    control = c; address = a; data_in = d;
    @(posedge clk); #1;
  endtask
  task automatic apply(input vec_t v, input string n);
    step(v.ctl, v.addr, v.din);
    chk({n, "_dout"}, v.dout, v.dout === 'x ? 64'd0 : v.dout);
    n_vec--;
    chk({n, "_dout"}, data_out, v.dout);
    chk({n, "_busy"}, 64'(busy), 64'(v.bsy));
    chk({n, "_end"}, 64'(end_op), 64'(v.eop));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 8; i++) t1[i] = '{C_LOAD, 64'(i), 64'(i) * K, 64'd0, 1'b0, 1'b0};
    t1[8]  = '{C_LOAD, 64'h8000000000000001, 64'hBAD, 64'd0, 1'b0, 1'b0};
    t1[9]  = '{C_LOAD, 64'd8, 64'hBAD, 64'd0, 1'b0, 1'b0};
    t1[10] = '{C_READ, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0};
    t1[11] = '{C_READ, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) t2[i] = '{C_READ, 64'(i), 64'd0, A5, 1'b0, 1'b1};
    t2[4] = '{C_READ, 64'd4, 64'd0, 64'h6402, 1'b0, 1'b1};
    t2[5] = '{4'd0, 64'd0, 64'd0, 64'h6402, 1'b0, 1'b1};
    t2[6] = '{C_READ, 64'd5, 64'd0, 64'd0, 1'b0, 1'b1};
    t2[7] = '{C_READ, 64'h8000000000000000, 64'd0, 64'd0, 1'b0, 1'b1};
    t2[8] = '{C_READ, 64'd4, 64'd0, 64'h6402, 1'b0, 1'b1};
    #12;
    chk("rst_dout", data_out, 64'd0);
    chk("rst_end", 64'(end_op), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cs", 64'(core_start), 64'd0);
    chk_din("rst_din");
    #10 rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) apply(t1[i], $sformatf("t1_%0d", i));
    for (int i = 0; i < 8; i++) din_m[i] = 64'(i) * K;
    chk_din("loaded_din");
    // run of exactly 100 cycles; a load and a start in RUN must be ignored
    core_dout = {4{64'h5A5A5A5A5A5A5A5A}};
    step(C_START, 64'd0, 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_cs1", 64'(core_start), 64'd1);
    step(C_LOAD | C_START, 64'd2, 64'hDEAD);
    chk("run_cs2", 64'(core_start), 64'd0);
    chk_din("run_locked");
    control = 0;
    core_dout = {4{A5}};
    repeat (98) @(posedge clk);
    #1 core_valid = 1;
    @(posedge clk); #1;
    core_valid = 0;
    core_dout = {4{64'h0123456789ABCDEF}};
    chk("done_end", 64'(end_op), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 9; i++) apply(t2[i], $sformatf("t2_%0d", i));
    step(C_LOAD, 64'd2, 64'hDEAD);
    din_m[2] = 64'hDEAD;
    chk_din("done_load");
    // load and start on the same edge
    step(C_START | C_LOAD, 64'd3, 64'hBEEF);
    din_m[3] = 64'hBEEF;
    chk("ls_cs", 64'(core_start), 64'd1);
    chk("ls_end", 64'(end_op), 64'd0);
    chk_din("ls_din");
    step(4'd0, 64'd0, 64'd0);
    chk("ls_cs_off", 64'(core_start), 64'd0);
    // rst_itf mid-RUN
    step(C_RST, 64'd0, 64'd0);
    din_m = '0;
    chk("ri_busy", 64'(busy), 64'd0);
    chk("ri_end", 64'(end_op), 64'd0);
    chk_din("ri_din");
    core_valid = 1;
    step(4'd0, 64'd0, 64'd0);
    step(4'd0, 64'd0, 64'd0);
    core_valid = 0;
    chk("ri_late_end", 64'(end_op), 64'd0);
    chk("ri_late_busy", 64'(busy), 64'd0);
    step(C_READ, 64'd4, 64'd0);
    chk("ri_status", data_out, 64'd0);
    step(C_READ, 64'd0, 64'd0);
    chk("ri_out0", data_out, 64'd0);
`ifdef CRYPTO_ITF_TIMEOUT_EN
    core_dout = {4{64'h3333333333333333}};
    step(C_START, 64'd0, 64'd0);
    core_valid = 1;
    step(4'd0, 64'd0, 64'd0);
    core_valid = 0;
    step(C_START, 64'd0, 64'd0);
    control = 0;
    repeat (15) @(posedge clk);
    #1 chk("to_busy15", 64'(busy), 64'd1);
    chk("to_end15", 64'(end_op), 64'd0);
    @(posedge clk); #1;
    chk("to_end16", 64'(end_op), 64'd1);
    step(C_READ, 64'd4, 64'd0);
    chk("to_status", data_out, 64'h1006);
    step(C_READ, 64'd0, 64'd0);
    chk("to_out0", data_out, 64'd0);
    core_valid = 1;
    step(C_READ, 64'd1, 64'd0);
    core_valid = 0;
    chk("to_late_out", data_out, 64'd0);
    chk("to_late_end", 64'(end_op), 64'd1);
    step(C_START, 64'd0, 64'd0);
    step(C_READ, 64'd4, 64'd0);
    chk("to_err_clr", data_out, 64'h1);
    step(C_RST, 64'd0, 64'd0);
`endif
    // core_valid on the core_start cycle, then async reset during a read
    step(C_START | C_LOAD, 64'd0, 64'd1);
    din_m[0] = 64'd1;
    chk("q_cs", 64'(core_start), 64'd1);
    chk_din("q_din");
    core_valid = 1;
    core_dout = {4{64'h7777777777777777}};
    step(4'd0, 64'd0, 64'd0);
    core_valid = 0;
    chk("q_end", 64'(end_op), 64'd1);
    step(C_READ, 64'd4, 64'd0);
    chk("q_status", data_out, 64'h102);
    step(C_READ, 64'd0, 64'd0);
    chk("q_out0", data_out, 64'h7777777777777777);
    #2 rst = 0;
    #1;
    din_m = '0;
    chk("ar_dout", data_out, 64'd0);
    chk("ar_end", 64'(end_op), 64'd0);
    chk_din("ar_din");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/crypto_core_itf.md
# crypto_core_itf

Parametrised host-to-core interface controller for the accelerators in se-qubip (X25519, EdDSA, and later cores). It gives the host an addressed input register bank, a start/done handshake to the core with cycle accounting, and an addressed output/status bank. Unlike a plain SIPO/PISO wrapper, it sequences the core through an explicit FSM. It also locks the input bank while the core runs, latches results only on completion, and exposes latency and error status to software.

## Interface
- DATA_W, 64: host bus word width
- IN_WORDS, 8: input bank depth in words (core operand width = IN_WORDS*DATA_W)
- OUT_WORDS, 4: output bank depth in words
- ADDR_W, 64: host address width; only low clog2(OUT_WORDS+1) / clog2(IN_WORDS) bits are decoded, upper bits must be zero or access is ignored
- CNT_W, 32: cycle counter width
- TIMEOUT, 2**20: RUN-state cycle limit (only with CRYPTO_ITF_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- control  in  4  {start, read, load, rst_itf}; bit0 rst_itf
- address  in  ADDR_W  word address
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  read data, registered
- end_op  out  1  result valid
- busy  out  1  core running
- core_start  out  1  one-cycle start pulse to core
- core_din  out  IN_WORDS*DATA_W  input bank, word 0 in LSBs
- core_dout  in  OUT_WORDS*DATA_W  core result
- core_valid  in  1  core completion, sampled only in RUN

## Operation
- States: IDLE, RUN, DONE. Reset and rst_itf → IDLE.
- IDLE:
  - load with address < IN_WORDS writes data_in to that word.
  - start → RUN.
- RUN:
  - busy=1; load is ignored (bank locked).
  - core_start=1 on the first RUN cycle only.
  - Cycle counter clears on RUN entry and increments every RUN cycle, saturating at 2^CNT_W−1.
  - core_valid=1 latches core_dout into the output bank → DONE.
- DONE:
  - end_op=1.
  - Loads are accepted.
  - start → RUN; end_op drops the same edge.
- start is ignored in RUN.
- Read:
  - address < OUT_WORDS returns an output word.
  - address == OUT_WORDS returns status: bit0 busy, bit1 end_op, bit2 err, bits[CNT_W+7:8] last cycle count (zero-extended/truncated to DATA_W).
  - Any other address returns 0.
- rst_itf (synchronous) clears both banks, the counter and err, and forces state to IDLE. It has priority over start and load.
- Simultaneous load and start in IDLE/DONE: the write lands on the same edge, so the core sees the updated bank when core_start is high.

## Timing
- Reset values: data_out=0, end_op=0, busy=0, core_start=0, core_din=0, banks=0, err=0, count=0.
- start at edge N → RUN, with busy and core_start high from N+1. core_start is low from N+2.
- core_valid high in RUN at edge M → output bank valid, DONE, and end_op high from M+1. Recorded count = RUN cycles inclusive of cycle M.
- core_valid on the core_start cycle is accepted (count=1).
- Read latency is 1 cycle: data_out updates on the edge after read is sampled and holds when read=0.
- Asynchronous rst mid-RUN aborts immediately. No core_start is reissued.

## Configuration
- CRYPTO_ITF_TIMEOUT_EN defined:
  - When the count reaches TIMEOUT in RUN, the block moves to DONE with err=1 and the output bank cleared to 0. end_op rises as normal.
  - Late core_valid is ignored.
  - err clears on the next start.
- Undefined: no timeout logic; err is tied 0; the block waits in RUN indefinitely.

## Structure
- Package crypto_itf_pkg: state enum (IDLE/RUN/DONE), control bit index constants, status bit positions, STATUS_ADDR offset helper.
- One sub-module, itf_reg_bank: addressed write-enable register array, shared for input (host write) and output (parallel capture, addressed read).

## Test plan
- Write words 0..7 = 0x1111…·i, start, core_valid after 100 cycles with core_dout=0xA5…; read 0..3 → 0xA5 words, status count=100, end_op=1.
- In RUN, load address 2 with 0xDEAD → core_din word 2 unchanged; in DONE the same load → updated.
- start and load on the same cycle → core_din holds the new word when core_start=1; core_start is high for exactly 1 cycle.
- rst_itf asserted in RUN → IDLE, busy=0, banks=0, later core_valid ignored (end_op stays 0).
- CRYPTO_ITF_TIMEOUT_EN with TIMEOUT=16, no core_valid → end_op at RUN cycle 16, status err=1, outputs 0; next start clears err.
- Read address OUT_WORDS+1 → 0; async rst mid-read → data_out=0 immediately.
